// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI arbiters: FSM encoding and burst-length width.
package axi_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_AW, ARB_W, ARB_B} arb_state_e;

  localparam int AXI_LEN_W = 8;

endpackage

// File: rtl/axi_rr_picker.sv
// Combinational round-robin picker: one-hot grant of the first request at or after i_ptr, wrapping.
module axi_rr_picker #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt
);

  logic w_found;

  // First pass covers [ptr, N-1]; the second pass wraps to [0, ptr-1].
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && i_req[i] && (i >= int'(i_ptr))) begin
        o_gnt[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_found && i_req[i]) begin
        o_gnt[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// N-to-1 AXI write arbiter: round-robin, one burst in flight, grant held from AW through B.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                              sig_clock,
  input  logic                              sig_reset,
  input  logic [NUM_MASTERS-1:0]            m_awvalid,
  output logic [NUM_MASTERS-1:0]            m_awready,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_awid,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_awaddr,
  input  logic [NUM_MASTERS*8-1:0]          m_awlen,
  input  logic [NUM_MASTERS*3-1:0]          m_awsize,
  input  logic [NUM_MASTERS*2-1:0]          m_awburst,
  input  logic [NUM_MASTERS-1:0]            m_wvalid,
  output logic [NUM_MASTERS-1:0]            m_wready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS*STRB_WIDTH-1:0] m_wstrb,
  input  logic [NUM_MASTERS-1:0]            m_wlast,
  output logic [NUM_MASTERS-1:0]            m_bvalid,
  input  logic [NUM_MASTERS-1:0]            m_bready,
  output logic [ID_WIDTH-1:0]               m_bid,
  output logic [1:0]                        m_bresp,
  output logic                              s_awvalid,
  input  logic                              s_awready,
  output logic [ID_WIDTH-1:0]               s_awid,
  output logic [ADDR_WIDTH-1:0]             s_awaddr,
  output logic [7:0]                        s_awlen,
  output logic [2:0]                        s_awsize,
  output logic [1:0]                        s_awburst,
  output logic                              s_wvalid,
  input  logic                              s_wready,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  output logic [STRB_WIDTH-1:0]             s_wstrb,
  output logic                              s_wlast,
  input  logic                              s_bvalid,
  output logic                              s_bready,
  input  logic [ID_WIDTH-1:0]               s_bid,
  input  logic [1:0]                        s_bresp,
  output logic [NUM_MASTERS-1:0]            grant,
  output logic                              err_wlast
);

  localparam int N     = NUM_MASTERS;
  localparam int PTR_W = $clog2(N);

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  logic [N-1:0]         r_grant;
  logic [N-1:0]         w_pick;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [PTR_W-1:0]     w_gidx;
  logic [AXI_LEN_W-1:0] r_beat_cnt;
  logic                 r_err_wlast;

  logic                  w_awvalid_g;
  logic [ID_WIDTH-1:0]   w_awid_g;
  logic [ADDR_WIDTH-1:0] w_awaddr_g;
  logic [7:0]            w_awlen_g;
  logic [2:0]            w_awsize_g;
  logic [1:0]            w_awburst_g;
  logic                  w_wvalid_g;
  logic [DATA_WIDTH-1:0] w_wdata_g;
  logic [STRB_WIDTH-1:0] w_wstrb_g;
  logic                  w_wlast_g;
  logic                  w_bready_g;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;

  axi_rr_picker #(.N(N), .PTR_W(PTR_W)) u_picker (
    .i_req (m_awvalid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick)
  );

  // Grant is one-hot or zero, so an AND-OR mux selects the owner's channels.
  always_comb begin
    w_awvalid_g = 1'b0;
    w_awid_g    = '0;
    w_awaddr_g  = '0;
    w_awlen_g   = '0;
    w_awsize_g  = '0;
    w_awburst_g = '0;
    w_wvalid_g  = 1'b0;
    w_wdata_g   = '0;
    w_wstrb_g   = '0;
    w_wlast_g   = 1'b0;
    w_bready_g  = 1'b0;
    w_gidx      = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant[i]) begin
        w_awvalid_g = m_awvalid[i];
        w_awid_g    = m_awid[i*ID_WIDTH +: ID_WIDTH];
        w_awaddr_g  = m_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_awlen_g   = m_awlen[i*8 +: 8];
        w_awsize_g  = m_awsize[i*3 +: 3];
        w_awburst_g = m_awburst[i*2 +: 2];
        w_wvalid_g  = m_wvalid[i];
        w_wdata_g   = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_wstrb_g   = m_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
        w_wlast_g   = m_wlast[i];
        w_bready_g  = m_bready[i];
        w_gidx      = PTR_W'(i);
      end
    end
  end

  assign w_aw_hs = (r_state == ARB_AW) && w_awvalid_g && s_awready;
  assign w_w_hs  = (r_state == ARB_W)  && w_wvalid_g  && s_wready;
  assign w_b_hs  = (r_state == ARB_B)  && s_bvalid    && w_bready_g;

  always_ff @(posedge sig_clock or negedge sig_reset) begin
    if (!sig_reset) r_state <= ARB_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (|m_awvalid) w_state_nxt = ARB_AW;
      ARB_AW:   if (w_aw_hs) w_state_nxt = ARB_W;
      ARB_W:    if (w_w_hs && (r_beat_cnt == '0)) w_state_nxt = ARB_B;
      ARB_B:    if (w_b_hs) w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    s_awvalid = (r_state == ARB_AW) && w_awvalid_g;
    m_awready = r_grant & {N{(r_state == ARB_AW) && s_awready}};
    s_awid    = w_awid_g;
    s_awaddr  = w_awaddr_g;
    s_awlen   = w_awlen_g;
    s_awsize  = w_awsize_g;
    s_awburst = w_awburst_g;
    s_wvalid  = (r_state == ARB_W) && w_wvalid_g;
    m_wready  = r_grant & {N{(r_state == ARB_W) && s_wready}};
    s_wdata   = w_wdata_g;
    s_wstrb   = w_wstrb_g;
    s_wlast   = w_wlast_g;
    m_bvalid  = r_grant & {N{(r_state == ARB_B) && s_bvalid}};
    s_bready  = (r_state == ARB_B) && w_bready_g;
    m_bid     = s_bid;
    m_bresp   = s_bresp;
    grant     = r_grant;
    err_wlast = r_err_wlast;
  end

  // beat_cnt holds beats remaining minus one; it stops at zero, so awlen=255 never wraps.
  always_ff @(posedge sig_clock or negedge sig_reset) begin
    if (!sig_reset) begin
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
      r_err_wlast <= 1'b0;
    end else begin
      r_err_wlast <= w_w_hs && (w_wlast_g != (r_beat_cnt == '0));
      if ((r_state == ARB_IDLE) && (|m_awvalid)) r_grant <= w_pick;
      if (w_aw_hs) r_beat_cnt <= w_awlen_g;
      else if (w_w_hs && (r_beat_cnt != '0)) r_beat_cnt <= r_beat_cnt - 1'b1;
      if (w_b_hs) begin
        r_grant  <= '0;
        r_rr_ptr <= (w_gidx == PTR_W'(N - 1)) ? '0 : w_gidx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: directed bursts, a per-cycle reference model and literal end-of-test checks.
module tb_axi_wr_arbiter;

  localparam int NM  = 2;
  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [NM-1:0]     m_awvalid = '0;
  logic [NM-1:0]     m_awready;
  logic [NM*IDW-1:0] m_awid    = '0;
  logic [NM*AW-1:0]  m_awaddr  = '0;
  logic [NM*8-1:0]   m_awlen   = '0;
  logic [NM*3-1:0]   m_awsize  = '0;
  logic [NM*2-1:0]   m_awburst = '0;
  logic [NM-1:0]     m_wvalid  = '0;
  logic [NM-1:0]     m_wready;
  logic [NM*DW-1:0]  m_wdata   = '0;
  logic [NM*SW-1:0]  m_wstrb   = '0;
  logic [NM-1:0]     m_wlast   = '0;
  logic [NM-1:0]     m_bvalid;
  logic [NM-1:0]     m_bready  = '1;
  logic [IDW-1:0]    m_bid;
  logic [1:0]        m_bresp;
  logic              s_awvalid;
  logic              s_awready = 1'b0;
  logic [IDW-1:0]    s_awid;
  logic [AW-1:0]     s_awaddr;
  logic [7:0]        s_awlen;
  logic [2:0]        s_awsize;
  logic [1:0]        s_awburst;
  logic              s_wvalid;
  logic              s_wready  = 1'b0;
  logic [DW-1:0]     s_wdata;
  logic [SW-1:0]     s_wstrb;
  logic              s_wlast;
  logic              s_bvalid  = 1'b0;
  logic              s_bready;
  logic [IDW-1:0]    s_bid     = '0;
  logic [1:0]        s_bresp   = '0;
  logic [NM-1:0]     grant;
  logic              err_wlast;

  axi_wr_arbiter #(
    .NUM_MASTERS(NM), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)
  ) dut (
    .sig_clock(clk), .sig_reset(rst_n),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid),
    .m_bresp(m_bresp), .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid),
    .s_bresp(s_bresp), .grant(grant), .err_wlast(err_wlast)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Burst plans per master: length (awlen) and the beat that carries a spurious wlast (-1 for none).
  int nb [NM];
  int bl [NM][8];
  int be [NM][8];
  bit wtoggle = 1'b0;

  // Master agent state
  int cur     [NM];
  int beat    [NM];
  bit aw_done [NM];

  // Handshake flags sampled on the falling edge
  logic [NM-1:0] aw_hs_s = '0;
  logic [NM-1:0] w_hs_s  = '0;
  bit            s_b_hs_s  = 1'b0;
  bit            sl_last_s = 1'b0;
  int            sl_len = 0;
  int            sl_cnt = 0;
  logic [IDW-1:0] sl_id = '0;

  // Observation logs
  logic [31:0] swq [$];
  int glog [$];
  int gcyc [$];
  int bcnt [NM];
  int bcyc [NM];
  int errcnt = 0;
  int cyc = 0;
  logic [NM-1:0] pg = '0;

  // Reference model
  int mo = -1;
  int mrr = 0;
  bit mawp = 1'b0;
  int mleft = 0;
  bit merr = 1'b0;

  initial begin
    for (int m = 0; m < NM; m++) begin
      nb[m] = 0; cur[m] = 0; beat[m] = 0; aw_done[m] = 0; bcnt[m] = 0; bcyc[m] = 0;
    end
  end

  // Master agents: AW and first W beat are presented together; W is held off by the arbiter.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int m = 0; m < NM; m++) begin
        if (!rst_n) begin
          cur[m] = 0; beat[m] = 0; aw_done[m] = 0;
        end else begin
          if (aw_hs_s[m]) aw_done[m] = 1;
          if (w_hs_s[m]) beat[m]++;
          if (cur[m] < nb[m] && aw_done[m] && beat[m] > bl[m][cur[m]]) begin
            cur[m]++; aw_done[m] = 0; beat[m] = 0;
          end
        end
        if (rst_n && cur[m] < nb[m]) begin
          m_awvalid[m]            = !aw_done[m];
          m_awid[m*IDW +: IDW]    = IDW'(m);
          m_awaddr[m*AW +: AW]    = 32'h1000 * (m + 1) + 32'h100 * cur[m];
          m_awlen[m*8 +: 8]       = 8'(bl[m][cur[m]]);
          m_awsize[m*3 +: 3]      = 3'd2;
          m_awburst[m*2 +: 2]     = 2'd1;
          m_wvalid[m]             = (beat[m] <= bl[m][cur[m]]);
          m_wdata[m*DW +: DW]     = {4'hA, 4'(m), 8'(cur[m]), 8'h5C, 8'(beat[m])};
          m_wstrb[m*SW +: SW]     = 4'hF;
          m_wlast[m]              = (beat[m] == bl[m][cur[m]]) || (beat[m] == be[m][cur[m]]);
        end else begin
          m_awvalid[m] = 1'b0;
          m_awid[m*IDW +: IDW] = '0;
          m_awaddr[m*AW +: AW] = '0;
          m_awlen[m*8 +: 8] = '0;
          m_awsize[m*3 +: 3] = '0;
          m_awburst[m*2 +: 2] = '0;
          m_wvalid[m] = 1'b0;
          m_wdata[m*DW +: DW] = '0;
          m_wstrb[m*SW +: SW] = '0;
          m_wlast[m] = 1'b0;
        end
      end
    end
  end

  // Slave agent: counts beats itself and answers OKAY one cycle after the final beat.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
      end else begin
        s_awready = 1'b1;
        s_wready  = wtoggle ? ~s_wready : 1'b1;
        if (s_b_hs_s) s_bvalid = 1'b0;
        if (sl_last_s) begin
          s_bvalid = 1'b1; s_bid = sl_id; s_bresp = 2'b00;
        end
      end
    end
  end

  // Falling-edge monitor: sample handshakes, log, compare against the model, then advance it.
  initial begin
    forever begin
      int o;
      bit in_aw, in_w, in_b, werr;
      logic [NM-1:0] eg, eawr, ewr, ebv;
      @(negedge clk);
      cyc++;
      aw_hs_s   = m_awvalid & m_awready;
      w_hs_s    = m_wvalid & m_wready;
      s_b_hs_s  = s_bvalid && s_bready;
      sl_last_s = 1'b0;
      if (!rst_n) begin
        swq.delete(); glog.delete(); gcyc.delete();
        for (int m = 0; m < NM; m++) begin bcnt[m] = 0; bcyc[m] = 0; end
        errcnt = 0; sl_cnt = 0; sl_len = 0; pg = '0;
        mo = -1; mrr = 0; mawp = 0; mleft = 0; merr = 0;
      end else begin
        if (s_awvalid && s_awready) begin sl_len = int'(s_awlen); sl_id = s_awid; end
        if (s_wvalid && s_wready) begin
          swq.push_back(s_wdata);
          sl_cnt++;
          if (sl_cnt == sl_len + 1) begin sl_last_s = 1'b1; sl_cnt = 0; end
        end
        for (int m = 0; m < NM; m++)
          if (m_bvalid[m] && m_bready[m]) begin bcnt[m]++; bcyc[m] = cyc; end
        if (err_wlast) errcnt++;
        for (int m = 0; m < NM; m++)
          if (grant[m] && (grant != pg)) begin glog.push_back(m); gcyc.push_back(cyc); end
        pg = grant;
      end

      o     = (mo < 0) ? 0 : mo;
      in_aw = (mo >= 0) && mawp;
      in_w  = (mo >= 0) && !mawp && (mleft > 0);
      in_b  = (mo >= 0) && !mawp && (mleft == 0);
      eg = '0; eawr = '0; ewr = '0; ebv = '0;
      if (mo >= 0) eg[o] = 1'b1;
      if (in_aw) eawr[o] = s_awready;
      if (in_w)  ewr[o]  = s_wready;
      if (in_b)  ebv[o]  = s_bvalid;
      chk("grant",     32'(grant),     32'(eg));
      chk("s_awvalid", 32'(s_awvalid), 32'(in_aw && m_awvalid[o]));
      chk("m_awready", 32'(m_awready), 32'(eawr));
      chk("s_awid",    32'(s_awid),    (mo >= 0) ? 32'(m_awid[o*IDW +: IDW]) : 32'h0);
      chk("s_awaddr",  32'(s_awaddr),  (mo >= 0) ? 32'(m_awaddr[o*AW +: AW]) : 32'h0);
      chk("s_awlen",   32'(s_awlen),   (mo >= 0) ? 32'(m_awlen[o*8 +: 8]) : 32'h0);
      chk("s_awsize",  32'(s_awsize),  (mo >= 0) ? 32'(m_awsize[o*3 +: 3]) : 32'h0);
      chk("s_awburst", 32'(s_awburst), (mo >= 0) ? 32'(m_awburst[o*2 +: 2]) : 32'h0);
      chk("s_wvalid",  32'(s_wvalid),  32'(in_w && m_wvalid[o]));
      chk("m_wready",  32'(m_wready),  32'(ewr));
      chk("s_wdata",   32'(s_wdata),   (mo >= 0) ? 32'(m_wdata[o*DW +: DW]) : 32'h0);
      chk("s_wstrb",   32'(s_wstrb),   (mo >= 0) ? 32'(m_wstrb[o*SW +: SW]) : 32'h0);
      chk("s_wlast",   32'(s_wlast),   32'((mo >= 0) && m_wlast[o]));
      chk("m_bvalid",  32'(m_bvalid),  32'(ebv));
      chk("s_bready",  32'(s_bready),  32'(in_b && m_bready[o]));
      chk("m_bid",     32'(m_bid),     32'(s_bid));
      chk("m_bresp",   32'(m_bresp),   32'(s_bresp));
      chk("err_wlast", 32'(err_wlast), 32'(merr));

      if (rst_n) begin
        werr = 1'b0;
        if (mo < 0) begin
          if (|m_awvalid) begin
            for (int k = NM - 1; k >= 0; k--)
              if (m_awvalid[(mrr + k) % NM]) mo = (mrr + k) % NM;
            mawp = 1'b1;
          end
        end else if (in_aw) begin
          if (m_awvalid[o] && s_awready) begin
            mawp = 1'b0; mleft = int'(m_awlen[o*8 +: 8]) + 1;
          end
        end else if (in_w) begin
          if (m_wvalid[o] && s_wready) begin
            werr = (m_wlast[o] != (mleft == 1)); mleft--;
          end
        end else if (s_bvalid && m_bready[o]) begin
          mrr = (mo + 1) % NM; mo = -1;
        end
        merr = werr;
      end
    end
  end

  task automatic load(input int m, input int len, input int eb);
    bl[m][nb[m]] = len;
    be[m][nb[m]] = eb;
    nb[m]++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    for (int m = 0; m < NM; m++) nb[m] = 0;
    wtoggle = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (!((cur[0] >= nb[0]) && (cur[1] >= nb[1]) && (mo < 0) && !s_bvalid) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: still busy after %0d cycles, required idle", nm, k);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_grant",    32'(grant),    32'h0);
    chk("reset_s_wvalid", 32'(s_wvalid), 32'h0);
    chk("reset_s_bready", 32'(s_bready), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single master, four beats, response only to master 0
    load(0, 3, -1);
    wait_idle("single");
    chk("single_beats", 32'(swq.size()), 32'd4);
    for (int i = 0; i < 4 && i < swq.size(); i++) chk("single_data", swq[i], 32'hA0005C00 + 32'(i));
    chk("single_b0", 32'(bcnt[0]), 32'd1);
    chk("single_b1", 32'(bcnt[1]), 32'd0);

    // Simultaneous request from reset: m0 first, m1 one idle cycle after m0's B handshake
    do_reset();
    load(0, 1, -1);
    load(1, 1, -1);
    wait_idle("simul");
    chk("simul_ngrants", 32'(glog.size()), 32'd2);
    if (glog.size() >= 2) begin
      chk("simul_first",  32'(glog[0]), 32'd0);
      chk("simul_second", 32'(glog[1]), 32'd1);
      chk("simul_latency", 32'(gcyc[1] - bcyc[0]), 32'd2);
    end

    // Fairness over six bursts
    do_reset();
    for (int i = 0; i < 3; i++) begin load(0, 0, -1); load(1, 2, -1); end
    wait_idle("fair");
    chk("fair_ngrants", 32'(glog.size()), 32'd6);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("fair_order", 32'(glog[i]), 32'(i % 2));

    // Backpressure on W with an eight-beat burst from master 1
    do_reset();
    wtoggle = 1'b1;
    load(1, 7, -1);
    wait_idle("bp");
    chk("bp_beats", 32'(swq.size()), 32'd8);
    for (int i = 0; i < 8 && i < swq.size(); i++) chk("bp_data", swq[i], 32'hA1005C00 + 32'(i));
    chk("bp_b1", 32'(bcnt[1]), 32'd1);

    // Early wlast on beat 2 of 4
    do_reset();
    load(0, 3, 1);
    wait_idle("wlast");
    chk("wlast_errs",  32'(errcnt), 32'd1);
    chk("wlast_beats", 32'(swq.size()), 32'd4);
    chk("wlast_b0",    32'(bcnt[0]), 32'd1);

    // Reset in the middle of a W burst
    do_reset();
    wtoggle = 1'b1;
    load(0, 7, -1);
    k = 0;
    while (swq.size() < 2 && k < 200) begin @(negedge clk); k++; end
    chk("midw_grant_before", 32'(grant), 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    for (int m = 0; m < NM; m++) nb[m] = 0;
    @(negedge clk);
    chk("midw_s_wvalid",  32'(s_wvalid),  32'h0);
    chk("midw_s_awvalid", 32'(s_awvalid), 32'h0);
    chk("midw_grant",     32'(grant),     32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midw_idle_after", 32'(grant), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
